// File: rtl/alu_seq_n_if.sv
// alu_seq_n_if: operand/result handshake bundle for the sequential ALU.
//   in_valid/in_ready  : operation request handshake (source -> ALU)
//   op, a, b           : opcode and operands, sampled on the accept edge
//   use_acc            : take operand A from the accumulator (ALU_SEQ_ACC_EN only)
//   out_valid/out_ready: result handshake (ALU -> consumer)
//   result             : WIDTH+1 bits, top bit is carry / extra bit
//   zero, neg, ovf     : status flags registered with result
// Modports: master = operand source / result consumer, slave = the ALU.
// Optional macro: ALU_SEQ_ACC_EN adds use_acc.
interface alu_seq_n_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ALU_SEQ_ACC_EN
    logic             use_acc;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             zero;
    logic             neg;
    logic             ovf;

`ifdef ALU_SEQ_ACC_EN
    modport master (output in_valid, op, a, b, use_acc, out_ready,
                    input  in_ready, out_valid, result, zero, neg, ovf);
    modport slave  (input  in_valid, op, a, b, use_acc, out_ready,
                    output in_ready, out_valid, result, zero, neg, ovf);
`else
    modport master (output in_valid, op, a, b, out_ready,
                    input  in_ready, out_valid, result, zero, neg, ovf);
    modport slave  (input  in_valid, op, a, b, out_ready,
                    output in_ready, out_valid, result, zero, neg, ovf);
`endif
endinterface

// File: rtl/alu_seq_n.sv
// alu_seq_n: clocked N-bit ALU with valid/ready handshakes.
//   Single-cycle ops (add/sub/inc/dec/logic/zero-distance shift/reserved)
//   finish on the accept edge; shifts walk one position per BUSY cycle and
//   MUL runs a WIDTH-step shift-add.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_n_if.slave (request, operands, result, flags)
// Optional macro: ALU_SEQ_ACC_EN adds an accumulator loaded on every result
//   handshake; use_acc=1 at accept selects it as operand A.
module alu_seq_n #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_n_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;  // counter must hold WIDTH for MUL
    localparam logic [CW-1:0] CNT_ONE = {{SW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SAR = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;       // shift working value
    logic [WIDTH-1:0]   r_b;       // MUL multiplier, shifted right each step
    logic [CW-1:0]      r_cnt;
    logic               r_sbit;    // last bit shifted out
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH:0]     r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;
    logic               r_out_valid;
`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0]   r_acc;
`endif

    // {zero, neg} derived from the data part of a result
    function automatic logic [1:0] flags_zn(input logic [WIDTH:0] res);
        flags_zn = {(res[WIDTH-1:0] == {WIDTH{1'b0}}), res[WIDTH-1]};
    endfunction

    logic [WIDTH-1:0] w_opa;
    logic             w_accept;
    logic [SW-1:0]    w_shamt;
    logic             w_multi;

`ifdef ALU_SEQ_ACC_EN
    assign w_opa = bus.use_acc ? r_acc : bus.a;
`else
    assign w_opa = bus.a;
`endif
    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_shamt  = bus.b[SW-1:0];
    assign w_multi  = (bus.op == OP_MUL) ||
                      (((bus.op == OP_SAR) || (bus.op == OP_SHR) || (bus.op == OP_SHL)) &&
                       (w_shamt != {SW{1'b0}}));

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH-1:0] w_logic_res;

    // Decode single-cycle ops into adder operands or a bitwise result
    always_comb begin
        w_b_eff     = {WIDTH{1'b0}};
        w_cin       = 1'b0;
        w_arith     = 1'b0;
        w_logic_res = {WIDTH{1'b0}};
        case (bus.op)
            OP_ADD: begin w_b_eff = bus.b;          w_arith = 1'b1; end
            OP_SUB: begin w_b_eff = ~bus.b;         w_cin = 1'b1; w_arith = 1'b1; end
            OP_INC: begin w_b_eff = {WIDTH{1'b0}};  w_cin = 1'b1; w_arith = 1'b1; end
            OP_DEC: begin w_b_eff = {WIDTH{1'b1}};  w_arith = 1'b1; end
            OP_XOR: w_logic_res = w_opa ^ bus.b;
            OP_OR:  w_logic_res = w_opa | bus.b;
            OP_AND: w_logic_res = w_opa & bus.b;
            OP_NOT: w_logic_res = ~w_opa;
            OP_SAR, OP_SHR, OP_SHL: w_logic_res = w_opa;  // zero-distance shift
            default: w_logic_res = {WIDTH{1'b0}};
        endcase
    end

    // Adder split at the MSB so carry-in and carry-out of the top bit are both visible
    logic [WIDTH-1:0] w_low;
    logic [1:0]       w_msb;
    logic [WIDTH:0]   w_sum;
    logic             w_add_ovf;
    logic [WIDTH:0]   w_single_res;

    assign w_low = {1'b0, w_opa[WIDTH-2:0]} + {1'b0, w_b_eff[WIDTH-2:0]} +
                   {{(WIDTH-1){1'b0}}, w_cin};
    assign w_msb = {1'b0, w_opa[WIDTH-1]} + {1'b0, w_b_eff[WIDTH-1]} + {1'b0, w_low[WIDTH-1]};
    assign w_sum = {w_msb, w_low[WIDTH-2:0]};
    assign w_add_ovf    = w_low[WIDTH-1] ^ w_msb[1];
    assign w_single_res = w_arith ? w_sum : {1'b0, w_logic_res};

    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_bit;

    // One-position shift step of the working value
    always_comb begin
        w_sh_next = r_a;
        w_sh_bit  = r_sbit;
        case (r_op[1:0])
            2'b00: begin w_sh_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]}; w_sh_bit = r_a[0]; end
            2'b01: begin w_sh_next = {1'b0, r_a[WIDTH-1:1]};         w_sh_bit = r_a[0]; end
            2'b10: begin w_sh_next = {r_a[WIDTH-2:0], 1'b0};         w_sh_bit = r_a[WIDTH-1]; end
            default: begin w_sh_next = r_a; w_sh_bit = r_sbit; end
        endcase
    end

    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_busy_res;

    assign w_prod_next = r_b[0] ? (r_prod + r_mcand) : r_prod;
    assign w_busy_res  = (r_op == OP_MUL) ?
                         {(|w_prod_next[2*WIDTH-1:WIDTH]), w_prod_next[WIDTH-1:0]} :
                         {w_sh_bit, w_sh_next};

    // Control FSM with operand, datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 4'b0000;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_sbit      <= 1'b0;
            r_prod      <= {(2*WIDTH){1'b0}};
            r_mcand     <= {(2*WIDTH){1'b0}};
            r_result    <= {(WIDTH+1){1'b0}};
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
            r_acc       <= {WIDTH{1'b0}};
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= bus.op;
                        r_a  <= w_opa;
                        r_b  <= bus.b;
                        if (w_multi) begin
                            r_state <= S_BUSY;
                            r_cnt   <= (bus.op == OP_MUL) ? CNT_MUL : {1'b0, w_shamt};
                            r_sbit  <= 1'b0;
                            r_prod  <= {(2*WIDTH){1'b0}};
                            r_mcand <= {{WIDTH{1'b0}}, w_opa};
                        end else begin
                            r_state             <= S_DONE;
                            r_result            <= w_single_res;
                            {r_zero, r_neg}     <= flags_zn(w_single_res);
                            r_ovf               <= w_arith & w_add_ovf;
                            r_out_valid         <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_op == OP_MUL) begin
                        r_prod  <= w_prod_next;
                        r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
                        r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    end else begin
                        r_a    <= w_sh_next;
                        r_sbit <= w_sh_bit;
                    end
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state         <= S_DONE;
                        r_result        <= w_busy_res;
                        {r_zero, r_neg} <= flags_zn(w_busy_res);
                        r_ovf           <= 1'b0;
                        r_out_valid     <= 1'b1;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
                        r_acc       <= r_result[WIDTH-1:0];
`endif
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.ovf       = r_ovf;
endmodule
